// File: rtl/if_stage_fbuf.sv
// Instruction-fetch stage: one outstanding split-transaction SRAM fetch feeding a
// BUF_DEPTH-entry {inst, pc} buffer toward ID, with branch flush and fetch cancel.
module if_stage_fbuf #(
    parameter int               PC_WD     = 32,
    parameter int               INST_WD   = 32,
    parameter logic [PC_WD-1:0] RESET_PC  = 32'h8000_0000,
    parameter int               BUF_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_allowin,
    output logic                     if_to_id_valid,
    output logic [INST_WD+PC_WD-1:0] if_to_id_bus,
    input  logic                     br_valid,
    input  logic [PC_WD-1:0]         br_target,
    output logic                     inst_req,
    output logic [PC_WD-1:0]         inst_addr,
    input  logic                     inst_addr_ok,
    input  logic                     inst_data_ok,
    input  logic [INST_WD-1:0]       inst_rdata
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BUS_W = INST_WD + PC_WD;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PC_WD-1:0] r_fetch_pc;
    logic [PC_WD-1:0] r_req_pc;
    logic             r_cancel;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [BUS_W-1:0] r_buf [BUF_DEPTH];
    logic             w_resp_done;
    logic             w_push;
    logic             w_pop;
    logic             w_issue_ok;
    logic             w_issue;

    assign w_resp_done    = (r_state == RESP) && inst_data_ok;
    assign w_push         = w_resp_done && !r_cancel && !br_valid;
    assign if_to_id_valid = (r_count != '0) && !br_valid;
    assign w_pop          = if_to_id_valid && id_allowin;
    assign if_to_id_bus   = (r_count != '0) ? r_buf[r_rd_ptr] : '0;
    assign inst_req       = (r_state == REQ);
    assign inst_addr      = r_req_pc;

    always_comb begin
        w_count_next = r_count;
        if (br_valid)
            w_count_next = '0;
        else if (w_push && !w_pop)
            w_count_next = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CNT_W'(1);
    end

    // A slot is reserved at issue time, so returning data can never overflow the buffer.
    assign w_issue_ok = !br_valid && (w_count_next < CNT_W'(BUF_DEPTH));

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue_ok) begin
                    w_state_next = REQ;
                    w_issue      = 1'b1;
                end
            end
            REQ: begin
                if (inst_addr_ok)
                    w_state_next = RESP;
            end
            RESP: begin
                if (inst_data_ok) begin
                    if (w_issue_ok) begin
                        w_state_next = REQ;
                        w_issue      = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_cancel   <= 1'b0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (br_valid)
                r_fetch_pc <= br_target;
            else if (w_issue)
                r_fetch_pc <= r_fetch_pc + PC_WD'(4);
            if (w_issue)
                r_req_pc <= r_fetch_pc;
            // The fetch already on the bus cannot be withdrawn; mark its data for dropping.
            if (w_resp_done)
                r_cancel <= 1'b0;
            else if (br_valid && (r_state == REQ || r_state == RESP))
                r_cancel <= 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (br_valid)
                r_rd_ptr <= r_wr_ptr;
            else if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_buf[r_wr_ptr] <= {inst_rdata, r_req_pc};
    end

endmodule

// File: tb/tb_if_stage_fbuf.sv
// Directed bench for if_stage_fbuf with a small reactive instruction-SRAM model.
module tb_if_stage_fbuf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_allowin = 1'b0;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;

    logic        addr_gate = 1'b1;
    logic        data_gate = 1'b1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    if_stage_fbuf dut (
        .clk            (clk),
        .reset          (reset),
        .id_allowin     (id_allowin),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_bus   (if_to_id_bus),
        .br_valid       (br_valid),
        .br_target      (br_target),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive();
        inst_addr_ok = inst_req && addr_gate;
        inst_data_ok = pend && data_gate;
        inst_rdata   = pend ? inst_of(pend_addr) : 32'h0;
    endtask

    // Advance one clock; SRAM model accepts on addr_ok and answers when data_gate allows.
    task automatic tick();
        logic        acc;
        logic        ret;
        logic [31:0] a;
        acc = inst_req && inst_addr_ok;
        ret = inst_data_ok;
        a   = inst_addr;
        @(posedge clk);
        if (ret) pend = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = a;
        end
        #1;
        drive();
        #1;
    endtask

    task automatic pop_now(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {63'd0, if_to_id_valid}, 64'd1);
        chk(tag, if_to_id_bus, {inst_of(pc), pc});
        tick();
    endtask

    task automatic expect_pop(input string tag, input logic [31:0] pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (if_to_id_valid && id_allowin) begin
                seen = 1'b1;
                chk(tag, if_to_id_bus, {inst_of(pc), pc});
            end
            tick();
        end
        if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        // Reset held
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, if_to_id_valid}, 64'd0);
        chk("rst_bus", if_to_id_bus, 64'd0);
        chk("rst_req", {63'd0, inst_req}, 64'd0);
        chk("rst_addr", {32'd0, inst_addr}, 64'd0);

        // Sequential fetch with zero-wait SRAM
        reset = 1'b0;
        id_allowin = 1'b1;
        drive();
        #1;
        expect_pop("seq0", 32'h8000_0000);
        expect_pop("seq1", 32'h8000_0004);
        expect_pop("seq2", 32'h8000_0008);

        // Back-pressure fills exactly BUF_DEPTH entries
        id_allowin = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("full_valid", {63'd0, if_to_id_valid}, 64'd1);
        chk("full_req", {63'd0, inst_req}, 64'd0);
        chk("full_last_addr", {32'd0, inst_addr}, {32'd0, 32'h8000_0018});
        tick();
        tick();
        chk("full_req_hold", {63'd0, inst_req}, 64'd0);
        id_allowin = 1'b1;
        #1;
        pop_now("drain0", 32'h8000_000C);
        pop_now("drain1", 32'h8000_0010);
        pop_now("drain2", 32'h8000_0014);
        pop_now("drain3", 32'h8000_0018);
        expect_pop("resume0", 32'h8000_001C);
        expect_pop("resume1", 32'h8000_0020);

        // Redirect while waiting for data
        data_gate = 1'b0;
        drive();
        #1;
        for (int i = 0; i < 10 && !pend; i++) tick();
        if (!pend) chk("resp_wait_timeout", 64'd0, 64'd1);
        br_valid  = 1'b1;
        br_target = 32'h8000_0100;
        #1;
        chk("br_resp_mask", {63'd0, if_to_id_valid}, 64'd0);
        tick();
        br_valid  = 1'b0;
        data_gate = 1'b1;
        drive();
        #1;
        chk("br_resp_flushed", {63'd0, if_to_id_valid}, 64'd0);
        tick();
        chk("br_resp_req", {63'd0, inst_req}, 64'd1);
        chk("br_resp_addr", {32'd0, inst_addr}, {32'd0, 32'h8000_0100});
        expect_pop("br_resp_first", 32'h8000_0100);

        // Redirect during REQ with addr_ok withheld three cycles
        addr_gate = 1'b0;
        drive();
        #1;
        tick();
        chk("br_req_req", {63'd0, inst_req}, 64'd1);
        chk("br_req_addr", {32'd0, inst_addr}, {32'd0, 32'h8000_0108});
        br_valid  = 1'b1;
        br_target = 32'h8000_0100;
        #1;
        chk("br_req_mask", {63'd0, if_to_id_valid}, 64'd0);
        tick();
        br_valid = 1'b0;
        #1;
        chk("br_req_hold1", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h8000_0108});
        tick();
        chk("br_req_hold2", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h8000_0108});
        addr_gate = 1'b1;
        drive();
        #1;
        tick();
        chk("br_req_drop_empty", {63'd0, if_to_id_valid}, 64'd0);
        tick();
        chk("br_req_new_addr", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h8000_0100});
        expect_pop("br_req_first", 32'h8000_0100);

        // Redirect coinciding with data_ok and a pending pop
        id_allowin = 1'b0;
        tick();
        tick();
        chk("co_pre_valid", {63'd0, if_to_id_valid}, 64'd1);
        chk("co_pre_data_ok", {63'd0, inst_data_ok}, 64'd1);
        id_allowin = 1'b1;
        br_valid   = 1'b1;
        br_target  = 32'h8000_0300;
        #1;
        chk("co_mask", {63'd0, if_to_id_valid}, 64'd0);
        tick();
        br_valid = 1'b0;
        #1;
        chk("co_empty_valid", {63'd0, if_to_id_valid}, 64'd0);
        chk("co_empty_bus", if_to_id_bus, 64'd0);
        chk("co_idle_req", {63'd0, inst_req}, 64'd0);
        tick();
        chk("co_new_addr", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h8000_0300});
        expect_pop("co_first", 32'h8000_0300);

        // Asynchronous reset in the middle of RESP
        id_allowin = 1'b0;
        tick();
        tick();
        data_gate = 1'b0;
        drive();
        #1;
        chk("mid_pre_valid", {63'd0, if_to_id_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, if_to_id_valid}, 64'd0);
        chk("mid_rst_bus", if_to_id_bus, 64'd0);
        chk("mid_rst_req", {63'd0, inst_req}, 64'd0);
        chk("mid_rst_addr", {32'd0, inst_addr}, 64'd0);
        tick();
        tick();
        reset      = 1'b0;
        data_gate  = 1'b1;
        id_allowin = 1'b1;
        drive();
        #1;
        chk("rel_stale_data_ok", {63'd0, inst_data_ok}, 64'd1);
        chk("rel_valid", {63'd0, if_to_id_valid}, 64'd0);
        tick();
        chk("rel_first_addr", {31'd0, inst_req, inst_addr}, {31'd0, 1'b1, 32'h8000_0000});
        expect_pop("rel_first_pop", 32'h8000_0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
